// File: rtl/rename_pkg.sv
// Shared sizes and types for the register alias table and its checkpoint bank.
package rename_pkg;
   localparam int NUM_ARCH = 32;
   localparam int NUM_PHYS = 128;
   localparam int NUM_CKPT = 8;
   localparam int AREG_W   = 5;
   localparam int PTAG_W   = 7;
   localparam int CKPT_W   = 3;
   localparam int MAP_W    = NUM_ARCH * PTAG_W;

   typedef logic [AREG_W-1:0] areg_t;
   typedef logic [PTAG_W-1:0] ptag_t;
   typedef logic [CKPT_W-1:0] ckpt_id_t;

   // The whole map travels as one flat vector; entry a sits at bits [a*PTAG_W +: PTAG_W].
   function automatic ptag_t map_rd(input logic [MAP_W-1:0] m, input areg_t a);
      return m[a*PTAG_W +: PTAG_W];
   endfunction
endpackage

// File: rtl/rat_ckpt_bank.sv
// Branch checkpoint storage: NUM_CKPT full copies of the rename map,
// one whole-map write port and one whole-map read port.
import rename_pkg::*;

module rat_ckpt_bank (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [CKPT_W-1:0] wr_id,
   input  logic [MAP_W-1:0]  wr_map,
   input  logic [CKPT_W-1:0] rd_id,
   output logic [MAP_W-1:0]  rd_map
);
   logic [MAP_W-1:0] mem [NUM_CKPT];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_id] <= wr_map;
   end

   assign rd_map = mem[rd_id];
endmodule

// File: rtl/rat_rename.sv
// Register alias table: renames one instruction per cycle with branch checkpoints.
// Define RAT_ZERO_REG_EN to hardwire architectural register 0 to physical tag 0.
import rename_pkg::*;

module rat_rename (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AREG_W-1:0] in_rs1,
   input  logic [AREG_W-1:0] in_rs2,
   input  logic [AREG_W-1:0] in_rd,
   input  logic              in_rd_we,
   input  logic              in_branch,
   input  logic              free_valid,
   input  logic [PTAG_W-1:0] free_tag,
   output logic              free_pop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PTAG_W-1:0] out_ps1,
   output logic [PTAG_W-1:0] out_ps2,
   output logic [PTAG_W-1:0] out_pd,
   output logic [PTAG_W-1:0] out_old_pd,
   output logic              out_pd_we,
   output logic              out_ckpt_valid,
   output logic [CKPT_W-1:0] out_ckpt_id,
   input  logic              restore,
   input  logic [CKPT_W-1:0] restore_id,
   input  logic              ckpt_release,
   output logic              ckpt_full
);
   logic [MAP_W-1:0] map_q, map_upd, ckpt_map;
   ckpt_id_t         head_q, tail_q;
   logic [CKPT_W:0]  count_q, count_next;
   logic             need_pd, accept, take_ckpt, rel_ok;
   ptag_t            ps1, ps2;

   always_comb begin
`ifdef RAT_ZERO_REG_EN
      need_pd = in_rd_we && (in_rd != '0);
      ps1     = (in_rs1 == '0) ? '0 : map_rd(map_q, in_rs1);
      ps2     = (in_rs2 == '0) ? '0 : map_rd(map_q, in_rs2);
`else
      need_pd = in_rd_we;
      ps1     = map_rd(map_q, in_rs1);
      ps2     = map_rd(map_q, in_rs2);
`endif
   end

   assign in_ready  = (!out_valid || out_ready) && !restore && (!need_pd || free_valid)
                      && (!in_branch || !ckpt_full);
   assign accept    = in_valid && in_ready;
   assign free_pop  = accept && need_pd;
   assign take_ckpt = accept && in_branch;

   // The checkpoint image already contains the branch's own destination update.
   always_comb begin
      map_upd = map_q;
      if (need_pd) map_upd[in_rd*PTAG_W +: PTAG_W] = free_tag;
   end

   // A restore keeps every checkpoint from head up to restore_id, so it always leaves at least one.
   assign rel_ok = ckpt_release && (restore || count_q != '0);

   always_comb begin
      count_next = count_q;
      if (restore)        count_next = {1'b0, ckpt_id_t'(restore_id - head_q)} + 1'b1;
      else if (take_ckpt) count_next = count_q + 1'b1;
      if (rel_ok)         count_next = count_next - 1'b1;
   end

   rat_ckpt_bank u_bank (
      .clk    (clk),
      .wr_en  (take_ckpt),
      .wr_id  (tail_q),
      .wr_map (map_upd),
      .rd_id  (restore_id),
      .rd_map (ckpt_map)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ARCH; i++) map_q[i*PTAG_W +: PTAG_W] <= ptag_t'(i);
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         ckpt_full      <= 1'b0;
         out_valid      <= 1'b0;
         out_ps1        <= '0;
         out_ps2        <= '0;
         out_pd         <= '0;
         out_old_pd     <= '0;
         out_pd_we      <= 1'b0;
         out_ckpt_valid <= 1'b0;
         out_ckpt_id    <= '0;
      end else begin
         if (restore)     map_q <= ckpt_map;
         else if (accept) map_q <= map_upd;

         if (restore)        tail_q <= restore_id + 1'b1;
         else if (take_ckpt) tail_q <= tail_q + 1'b1;
         if (rel_ok) head_q <= head_q + 1'b1;
         count_q   <= count_next;
         ckpt_full <= (count_next == (CKPT_W+1)'(NUM_CKPT));

         // A restore flushes the held result: it belongs to a younger instruction.
         if (restore)        out_valid <= 1'b0;
         else if (accept)    out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (accept) begin
            out_ps1        <= ps1;
            out_ps2        <= ps2;
            out_pd         <= need_pd ? free_tag : '0;
            out_old_pd     <= map_rd(map_q, in_rd);
            out_pd_we      <= need_pd;
            out_ckpt_valid <= in_branch;
            out_ckpt_id    <= tail_q;
         end
      end
   end
endmodule

// File: tb/tb_rat_rename.sv
// Randomized bench for rat_rename against an array/queue model of the rename map and checkpoint list.
module tb_rat_rename;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_ready;
   logic [4:0] in_rs1, in_rs2, in_rd;
   logic       in_rd_we, in_branch;
   logic       free_valid;
   logic [6:0] free_tag;
   logic       free_pop;
   logic       out_valid, out_ready;
   logic [6:0] out_ps1, out_ps2, out_pd, out_old_pd;
   logic       out_pd_we, out_ckpt_valid;
   logic [2:0] out_ckpt_id;
   logic       restore;
   logic [2:0] restore_id;
   logic       ckpt_release;
   logic       ckpt_full;

   rat_rename dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rd_we(in_rd_we), .in_branch(in_branch),
      .free_valid(free_valid), .free_tag(free_tag), .free_pop(free_pop),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
      .out_pd_we(out_pd_we), .out_ckpt_valid(out_ckpt_valid), .out_ckpt_id(out_ckpt_id),
      .restore(restore), .restore_id(restore_id), .ckpt_release(ckpt_release),
      .ckpt_full(ckpt_full)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: the map as an int array, live checkpoints as an ordered queue of ids.
   int rmap [32];
   int ck_map [8][32];
   int ckq [$];
   int next_id;
   bit m_ov, m_pdwe, m_ckv;
   int m_ps1, m_ps2, m_pd, m_old, m_ckid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) rmap[i] = i;
      ckq.delete();
      next_id = 0;
      m_ov = 0; m_pdwe = 0; m_ckv = 0;
      m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_old = 0; m_ckid = 0;
   endtask

   function automatic int src_tag(input int r);
`ifdef RAT_ZERO_REG_EN
      if (r == 0) return 0;
`endif
      return rmap[r];
   endfunction

   task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                        input bit we, input bit br, input int ft);
      in_valid = v; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd);
      in_rd_we = we; in_branch = br; free_tag = 7'(ft);
      free_valid = 1'b1; out_ready = 1'b1; restore = 1'b0; restore_id = 3'd0;
      ckpt_release = 1'b0; reset = 1'b0;
   endtask

   // One clock: check handshake, advance model at the edge, check registered outputs.
   task automatic step();
      bit need, exp_rdy, acc, rel;
      int rd, rid;
      rd   = int'(in_rd);
      need = in_rd_we;
`ifdef RAT_ZERO_REG_EN
      need = in_rd_we && (rd != 0);
`endif
      exp_rdy = (!m_ov || out_ready) && !restore && (!need || free_valid)
                && (!in_branch || ckq.size() < 8);
      acc = in_valid && exp_rdy;
      #1;
      check("in_ready", in_ready, exp_rdy);
      check("free_pop", free_pop, acc && need);
      @(posedge clk);
      rel = ckpt_release && ckq.size() > 0;
      if (reset) begin
         model_reset();
      end else if (restore) begin
         rid = int'(restore_id);
         while (ckq.size() > 0 && ckq[ckq.size()-1] != rid) void'(ckq.pop_back());
         for (int i = 0; i < 32; i++) rmap[i] = ck_map[rid][i];
         next_id = (rid + 1) % 8;
         m_ov = 0;
         if (ckpt_release && ckq.size() > 0) void'(ckq.pop_front());
      end else begin
         if (acc) begin
            m_ps1  = src_tag(int'(in_rs1));
            m_ps2  = src_tag(int'(in_rs2));
            m_old  = rmap[rd];
            m_pdwe = need;
            m_pd   = int'(free_tag);
            if (need) rmap[rd] = int'(free_tag);
            m_ckv = in_branch;
            if (in_branch) begin
               m_ckid = next_id;
               for (int i = 0; i < 32; i++) ck_map[next_id][i] = rmap[i];
               ckq.push_back(next_id);
               next_id = (next_id + 1) % 8;
            end
            m_ov = 1;
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (rel) void'(ckq.pop_front());
      end
      @(negedge clk);
      check("out_valid", out_valid, m_ov);
      check("ckpt_full", ckpt_full, ckq.size() == 8);
      check("out_ps1", out_ps1, m_ps1);
      check("out_ps2", out_ps2, m_ps2);
      check("out_pd_we", out_pd_we, m_pdwe);
      check("out_ckpt_valid", out_ckpt_valid, m_ckv);
      if (m_pdwe) begin
         check("out_pd", out_pd, m_pd);
         check("out_old_pd", out_old_pd, m_old);
      end
      if (m_ckv) check("out_ckpt_id", out_ckpt_id, m_ckid);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_ckpt_full", ckpt_full, 0);
      check("rst_out_ps1", out_ps1, 0);

      drive(1, 3, 4, 0, 0, 0, 0);   step();
      check("tp_src_ps1", out_ps1, 3);
      check("tp_src_ps2", out_ps2, 4);
      drive(1, 1, 2, 5, 1, 0, 32);  step();
      check("tp_rd5_pd", out_pd, 32);
      check("tp_rd5_old", out_old_pd, 5);
      drive(1, 5, 0, 0, 0, 0, 0);   step();
      check("tp_rs5_after", out_ps1, 32);
      drive(1, 7, 0, 7, 1, 0, 40);  step();
      check("tp_rs_eq_rd_ps1", out_ps1, 7);
      check("tp_rs_eq_rd_old", out_old_pd, 7);
      drive(1, 7, 0, 0, 0, 1, 0);   step();
      check("tp_ckpt_id0", out_ckpt_id, 0);
      check("tp_ps_map7", out_ps1, 40);
      drive(1, 0, 0, 5, 1, 0, 41);  step();
      check("tp_rd5_pd41", out_pd, 41);
      drive(1, 5, 0, 0, 0, 0, 0);
      restore = 1'b1; restore_id = 3'd0; step();
      check("tp_restore_drop", out_valid, 0);
      drive(1, 5, 0, 0, 0, 0, 0);   step();
      check("tp_restored_map", out_ps1, 32);

      for (int i = 0; i < 7; i++) begin
         drive(1, i, i, 0, 0, 1, 0); step();
      end
      check("tp_full", ckpt_full, 1);
      drive(1, 1, 1, 0, 0, 1, 0);   step();
      check("tp_9th_stalled", out_valid, 0);
      drive(1, 1, 1, 0, 0, 1, 0);
      ckpt_release = 1'b1;          step();
      drive(1, 1, 1, 0, 0, 1, 0);   step();
      check("tp_after_release_ckv", out_ckpt_valid, 1);
      check("tp_after_release_id", out_ckpt_id, 0);

      drive(1, 0, 0, 9, 1, 0, 50);
      free_valid = 1'b0;            step();
      check("tp_free_empty", out_valid, 0);
      drive(1, 3, 0, 0, 0, 0, 0);
      out_ready = 1'b0;             step();
      drive(1, 4, 0, 0, 0, 0, 0);
      out_ready = 1'b0;             step();
      check("tp_hold_ps1", out_ps1, 3);

      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;                 step();
      drive(1, 5, 7, 0, 0, 0, 0);   step();
      check("tp_reset_map", out_ps1, 5);

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(99) < 80, $urandom_range(31), $urandom_range(31),
               $urandom_range(31), $urandom_range(99) < 70, $urandom_range(99) < 25,
               $urandom_range(127));
         free_valid   = $urandom_range(99) < 85;
         out_ready    = $urandom_range(99) < 75;
         ckpt_release = $urandom_range(99) < 20;
         if (ckq.size() > 0 && $urandom_range(99) < 5) begin
            restore    = 1'b1;
            restore_id = 3'(ckq[$urandom_range(ckq.size() - 1)]);
         end
         if ($urandom_range(999) < 3) begin
            reset = 1'b1; in_valid = 1'b0; restore = 1'b0;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
